ccr_bank_unit: RTL
==================

// Module: ccr_bank_unit
// PURPOSE
//  Registered, multi-context condition-code register (CCR) unit: NUM_CTX banks of CCR state, one per hardware context.
//  Each accepted instruction updates the zero/overflow/underflow flags; R_TYPE compares record their result;
//  B_TYPE branches consume (test-and-clear) their flag.
//  Sits between ALU writeback and branch resolution; the branch decision is returned one cycle after acceptance.
// PARAMETERS
//  DATA_W   32  ALU result width
//  CCR_W    32  CCR register width (>=9); bits [CCR_W-1:9] read as 0
//  NUM_CTX  4   number of CCR banks (power of 2, >=1)
//  CNT_W    8   event-counter width (used only with CCR_EVTCNT_EN)
// PORTS
//  clk       in   1            clock, rising edge
//  rst       in   1            asynchronous, active-high reset
//  in_valid  in   1            instruction accepted this cycle (no back-pressure; always accepted)
//  in_ctx    in   log2(NUM_CTX) target bank of the instruction
//  type_in   in   2            instruction type (`R_TYPE, `B_TYPE, ...)
//  op_in     in   4            opcode (`EQ..`GTE, `BEQ..`BGTE)
//  alu_in    in   DATA_W       ALU result
//  over      in   1            ALU overflow
//  under     in   1            ALU underflow
//  clr_valid in   1            clear-bank request
//  clr_ctx   in   log2(NUM_CTX) bank to clear
//  rd_ctx    in   log2(NUM_CTX) bank select for debug read
//  br_valid  out  1            branch result valid (registered)
//  br_out    out  1            branch taken (registered)
//  br_ctx    out  log2(NUM_CTX) context of the branch result (registered)
//  ccr_rd    out  CCR_W        CCR of bank rd_ctx (combinational read of state)
//  ovf_cnt   out  CNT_W        overflow+underflow event count of bank rd_ctx
// BEHAVIOUR
//  Reset: all banks 0, all counters 0, br_valid=0, br_out=0, br_ctx=0.
//  Flag map: [0] zero, [1] over, [2] under, [3] EQ, [4] NEQ, [5] LT, [6] LTE, [7] GT, [8] GTE.
//  in_valid=0: no bank changes; br_valid=0 next cycle.
//  in_valid=1, any type: bank[in_ctx][0]=(alu_in==0), [1]=over, [2]=under at the clock edge.
//  R_TYPE + compare op: flag bit for op := (alu_in!=0); other bits [8:3] hold. Non-compare R op: [8:3] hold.
//  B_TYPE + Bxx op: next cycle br_valid=1, br_ctx=in_ctx, br_out = pre-edge value of the matching bit;
//    that bit is cleared. Unknown B op: br_valid=1, br_out=0, no compare bit changes.
//  Other types: [8:3] hold, br_valid=0.
//  Latency: flags visible on ccr_rd the cycle after the edge; a branch in cycle N sees a compare from cycle N-1.
//  Bits [CCR_W-1:9] are never written and always read 0.
//  Simultaneous clr_valid and in_valid, same ctx: clear wins; bank and counter become 0; a branch in that
//    cycle still reports the pre-clear flag on br_out.
//  Different ctx: both take effect.
//  Async reset mid-operation: immediate return to reset state; a pending br_valid is dropped.
// CONFIGURATION
//  CCR_EVTCNT_EN defined: per-bank CNT_W saturating counter, +1 on each accepted instruction with over|under.
//    Holds at 2^CNT_W-1. Cleared by rst or clr_valid for that bank. ovf_cnt shows the rd_ctx counter.
//  Undefined: no counters synthesised; ovf_cnt tied to 0.
// STRUCTURE
//  Flag bit indices (CCR_ZERO..CCR_GTE) and CCR_USED_W=9 go in the shared opcodes.vh header,
//    next to the `R_TYPE/`B_TYPE/op defines.
//  Sub-module ccr_bank: one context's flag register, update/consume/clear logic and optional counter.
//    The top instantiates NUM_CTX copies via generate, decodes in_ctx/clr_ctx, muxes rd_ctx,
//    and registers the branch result.
// TESTING
//  1. Reset, then R `EQ ctx1 alu_in=1 -> ccr_rd(ctx1)=0x008; ctx0 stays 0x001-free (0x000).
//  2. R `LT ctx2 alu_in=1, next cycle B `BLT ctx2 -> next cycle br_valid=1, br_out=1, br_ctx=2; bit5 of ctx2 =0.
//     Repeat B `BLT -> br_out=0.
//  3. R `GT ctx0 alu_in=0 -> bit7=0, bit0=1; B `BGT ctx0 -> br_out=0.
//  4. Same cycle clr_valid ctx3 and B `BEQ ctx3 with bit3=1 -> br_out=1, ccr_rd(ctx3)=0x000 after the edge.
//  5. With CCR_EVTCNT_EN and CNT_W=2: 5 instructions with over=1 on ctx1 -> ovf_cnt=3 (saturated);
//     clr ctx1 -> 0. Without the macro -> ovf_cnt=0.
//  6. Assert rst mid-stream with br_valid pending -> br_valid=0 and all banks 0 without a clock edge.

Source files
------------

// File: rtl/ccr_bank_unit_pkg.sv
// Shared CCR flag indices, instruction type and opcode encodings for ccr_bank_unit.
// Compare and branch opcodes share codes; cmp_mask maps an opcode to its CCR compare bit.
package ccr_bank_unit_pkg;

  localparam int unsigned CCR_USED_W = 9;

  localparam int unsigned CCR_ZERO  = 0;
  localparam int unsigned CCR_OVER  = 1;
  localparam int unsigned CCR_UNDER = 2;
  localparam int unsigned CCR_EQ    = 3;
  localparam int unsigned CCR_NEQ   = 4;
  localparam int unsigned CCR_LT    = 5;
  localparam int unsigned CCR_LTE   = 6;
  localparam int unsigned CCR_GT    = 7;
  localparam int unsigned CCR_GTE   = 8;

  typedef enum logic [1:0] {
    R_TYPE = 2'b00,
    I_TYPE = 2'b01,
    B_TYPE = 2'b10,
    J_TYPE = 2'b11
  } instr_type_e;

  localparam logic [3:0] OP_EQ  = 4'd0;
  localparam logic [3:0] OP_NEQ = 4'd1;
  localparam logic [3:0] OP_LT  = 4'd2;
  localparam logic [3:0] OP_LTE = 4'd3;
  localparam logic [3:0] OP_GT  = 4'd4;
  localparam logic [3:0] OP_GTE = 4'd5;

  localparam logic [3:0] OP_BEQ  = OP_EQ;
  localparam logic [3:0] OP_BNEQ = OP_NEQ;
  localparam logic [3:0] OP_BLT  = OP_LT;
  localparam logic [3:0] OP_BLTE = OP_LTE;
  localparam logic [3:0] OP_BGT  = OP_GT;
  localparam logic [3:0] OP_BGTE = OP_GTE;

  // One-hot CCR bit addressed by a compare/branch opcode; zero for non-compare opcodes.
  function automatic logic [CCR_USED_W-1:0] cmp_mask(input logic [3:0] op);
    logic [CCR_USED_W-1:0] m;
    m = '0;
    case (op)
      OP_EQ:   m[CCR_EQ]  = 1'b1;
      OP_NEQ:  m[CCR_NEQ] = 1'b1;
      OP_LT:   m[CCR_LT]  = 1'b1;
      OP_LTE:  m[CCR_LTE] = 1'b1;
      OP_GT:   m[CCR_GT]  = 1'b1;
      OP_GTE:  m[CCR_GTE] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ccr_bank_unit_if.sv
// Instruction, clear, debug-read and branch-result signals of ccr_bank_unit.
interface ccr_bank_unit_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CCR_W   = 32,
  parameter int unsigned NUM_CTX = 4,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  logic              in_valid;
  logic [CTX_W-1:0]  in_ctx;
  logic [1:0]        type_in;
  logic [3:0]        op_in;
  logic [DATA_W-1:0] alu_in;
  logic              over;
  logic              under;
  logic              clr_valid;
  logic [CTX_W-1:0]  clr_ctx;
  logic [CTX_W-1:0]  rd_ctx;
  logic              br_valid;
  logic              br_out;
  logic [CTX_W-1:0]  br_ctx;
  logic [CCR_W-1:0]  ccr_rd;
  logic [CNT_W-1:0]  ovf_cnt;

  modport master (
    output in_valid, in_ctx, type_in, op_in, alu_in, over, under, clr_valid, clr_ctx, rd_ctx,
    input  br_valid, br_out, br_ctx, ccr_rd, ovf_cnt
  );

  modport slave (
    input  in_valid, in_ctx, type_in, op_in, alu_in, over, under, clr_valid, clr_ctx, rd_ctx,
    output br_valid, br_out, br_ctx, ccr_rd, ovf_cnt
  );

endinterface

// File: rtl/ccr_bank_unit_bank.sv
// One context's CCR flags: update, branch test-and-clear, bank clear.
// CCR_EVTCNT_EN adds a saturating over/underflow event counter; otherwise cnt is tied to 0.
module ccr_bank_unit_bank
  import ccr_bank_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd,
  input  logic                  clr,
  input  logic                  is_r,
  input  logic                  is_b,
  input  logic [CCR_USED_W-1:0] mask,
  input  logic                  zero,
  input  logic                  over,
  input  logic                  under,
  output logic [CCR_USED_W-1:0] flags,
  output logic [CNT_W-1:0]      cnt
);

  logic [CCR_USED_W-1:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (upd) begin
      flags_d[CCR_ZERO]  = zero;
      flags_d[CCR_OVER]  = over;
      flags_d[CCR_UNDER] = under;
      if (is_r) flags_d = zero ? (flags_d & ~mask) : (flags_d | mask);
      if (is_b) flags_d = flags_d & ~mask;
    end
    // Clear overrides a same-cycle update of this bank.
    if (clr) flags_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flags = flags_q;

`ifdef CCR_EVTCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (upd && (over || under) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/ccr_bank_unit.sv
// Multi-context CCR unit: NUM_CTX flag banks, debug read mux and registered branch result.
// Optional per-bank event counters are enabled with CCR_EVTCNT_EN.
module ccr_bank_unit
  import ccr_bank_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CCR_W   = 32,
  parameter int unsigned NUM_CTX = 4,
  parameter int unsigned CNT_W   = 8
) (
  input logic            clk,
  input logic            rst,
  ccr_bank_unit_if.slave bus
);

  localparam int unsigned CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  logic [DATA_W-1:0]     alu;
  logic                  zero;
  logic                  is_r;
  logic                  is_b;
  logic [CCR_USED_W-1:0] mask;
  logic [CCR_USED_W-1:0] flags [NUM_CTX];
  logic [CNT_W-1:0]      cnt   [NUM_CTX];

  assign alu  = bus.alu_in;
  assign zero = (alu == '0);
  assign is_r = (bus.type_in == R_TYPE);
  assign is_b = (bus.type_in == B_TYPE);
  assign mask = cmp_mask(bus.op_in);

  for (genvar g = 0; g < NUM_CTX; g++) begin : g_bank
    ccr_bank_unit_bank #(
      .CNT_W (CNT_W)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .upd   (bus.in_valid && (bus.in_ctx == CTX_W'(g))),
      .clr   (bus.clr_valid && (bus.clr_ctx == CTX_W'(g))),
      .is_r  (is_r),
      .is_b  (is_b),
      .mask  (mask),
      .zero  (zero),
      .over  (bus.over),
      .under (bus.under),
      .flags (flags[g]),
      .cnt   (cnt[g])
    );
  end

  // Upper CCR bits are never stored; zero-extension makes them read as 0.
  assign bus.ccr_rd  = CCR_W'(flags[bus.rd_ctx]);
  assign bus.ovf_cnt = cnt[bus.rd_ctx];

  logic             take;
  logic             br_hit;
  logic             br_valid_q;
  logic             br_out_q;
  logic [CTX_W-1:0] br_ctx_q;

  assign take   = bus.in_valid && is_b;
  // Pre-edge flag value, so a same-cycle clear still reports the old flag.
  assign br_hit = |(mask & flags[bus.in_ctx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_valid_q <= 1'b0;
      br_out_q   <= 1'b0;
      br_ctx_q   <= '0;
    end else begin
      br_valid_q <= take;
      br_out_q   <= take && br_hit;
      if (take) br_ctx_q <= bus.in_ctx;
    end
  end

  assign bus.br_valid = br_valid_q;
  assign bus.br_out   = br_out_q;
  assign bus.br_ctx   = br_ctx_q;

endmodule
